// File: rtl/vending_io_responder_pkg.sv
// Shared definitions for the vending machine I/O responder.
// Contents: register word offsets, STATUS bit positions, coin credit values,
// dispense FSM state encoding, and a saturating 8-bit add used for CREDIT.
package vending_io_responder_pkg;

  // Register selects, taken from memory_address[3:2]
  localparam logic [1:0] REG_STATUS   = 2'd0;  // 0x0
  localparam logic [1:0] REG_ACK      = 2'd1;  // 0x4
  localparam logic [1:0] REG_DISPENSE = 2'd2;  // 0x8
  localparam logic [1:0] REG_CREDIT   = 2'd3;  // 0xC

  // STATUS bit positions
  localparam int STAT_NICKEL = 0;
  localparam int STAT_DIME   = 1;
  localparam int STAT_REFUND = 2;
  localparam int STAT_BUSY   = 3;

  localparam logic [7:0] NICKEL_VALUE = 8'd5;
  localparam logic [7:0] DIME_VALUE   = 8'd10;

  typedef enum logic [1:0] {
    DS_IDLE  = 2'd0,
    DS_PULSE = 2'd1,
    DS_GAP   = 2'd2
  } dispense_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/vending_io_responder_sync_edge_detect.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Ports:
//   i_clock   - system clock
//   i_reset_n - asynchronous active-low reset
//   i_async   - asynchronous level from the machine
//   o_rise    - one-cycle pulse on a 0->1 transition of the synchronized level
module sync_edge_detect (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_rise
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [2:0] r_valid;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_valid <= 3'b000;
    end else begin
      r_meta  <= i_async;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_valid <= {r_valid[1:0], 1'b1};
    end
  end

  // r_valid[2] marks that r_prev holds a real post-reset sample, so a level
  // already high at reset release is taken as the previous value, not an edge.
  assign o_rise = r_valid[2] & r_sync & ~r_prev;

endmodule

// File: rtl/vending_io_responder.sv
// Memory-mapped responder for a coin-operated vending machine.
// Synchronizes coin/refund inputs, keeps pending-event and credit registers,
// and times the coin-return / vend output pulses.
// Ports:
//   clock, reset_n            - system clock, async active-low reset
//   memory_write_en/address/  - CPU store strobe, byte address, store data
//   memory_write_value
//   memory_read_value         - combinational load data
//   nickel, dime, refund      - asynchronous machine inputs
//   nickel_out, dime_out, vend- registered dispense drives
//   event_pending             - registered OR of STATUS pending bits
//
// state    | meaning
// DS_IDLE  | outputs low, accepts a DISPENSE store
// DS_PULSE | latched outputs high for PULSE_CYCLES cycles
// DS_GAP   | outputs low for GAP_CYCLES cycles, stores ignored
module vending_io_responder
  import vending_io_responder_pkg::*;
#(
  parameter int PULSE_CYCLES = 16,
  parameter int GAP_CYCLES   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        memory_write_en,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_value,
  output logic [31:0] memory_read_value,
  input  logic        nickel,
  input  logic        dime,
  input  logic        refund,
  output logic        nickel_out,
  output logic        dime_out,
  output logic        vend,
  output logic        event_pending
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  logic            w_nickel_evt;
  logic            w_dime_evt;
  logic            w_refund_evt;
  logic            w_mapped;
  logic [1:0]      w_sel;
  logic            w_wr_ack;
  logic            w_wr_dispense;
  logic            w_wr_credit;
  logic            w_busy;
  logic            w_dispense_go;
  logic [2:0]      w_pending_next;
  logic [7:0]      w_coin_add;
  logic [7:0]      w_credit_base;
  logic            w_unused_bits;

  logic [2:0]      r_pending;
  logic [7:0]      r_credit;
  logic            r_event_pending;
  dispense_state_e r_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_nickel_out;
  logic            r_dime_out;
  logic            r_vend;

  sync_edge_detect u_sync_nickel (
    .i_clock(clock), .i_reset_n(reset_n), .i_async(nickel), .o_rise(w_nickel_evt)
  );
  sync_edge_detect u_sync_dime (
    .i_clock(clock), .i_reset_n(reset_n), .i_async(dime), .o_rise(w_dime_evt)
  );
  sync_edge_detect u_sync_refund (
    .i_clock(clock), .i_reset_n(reset_n), .i_async(refund), .o_rise(w_refund_evt)
  );

  assign w_mapped      = (memory_address[31:4] == 28'd0);
  assign w_sel         = memory_address[3:2];
  assign w_wr_ack      = memory_write_en & w_mapped & (w_sel == REG_ACK);
  assign w_wr_dispense = memory_write_en & w_mapped & (w_sel == REG_DISPENSE);
  assign w_wr_credit   = memory_write_en & w_mapped & (w_sel == REG_CREDIT);
  assign w_busy        = (r_state != DS_IDLE);
  assign w_dispense_go = w_wr_dispense & ~w_busy & (|memory_write_value[2:0]);

  // Clear first, then OR in new events so a coincident event survives the ACK.
  assign w_pending_next = (r_pending & ~(w_wr_ack ? memory_write_value[2:0] : 3'b000))
                        | {w_refund_evt, w_dime_evt, w_nickel_evt};

  always_comb begin
    w_coin_add = 8'd0;
    if (w_nickel_evt) w_coin_add = w_coin_add + NICKEL_VALUE;
    if (w_dime_evt)   w_coin_add = w_coin_add + DIME_VALUE;
  end

  assign w_credit_base = w_wr_credit ? memory_write_value[7:0] : r_credit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending       <= 3'b000;
      r_credit        <= 8'd0;
      r_event_pending <= 1'b0;
    end else begin
      r_pending       <= w_pending_next;
      r_credit        <= sat_add8(w_credit_base, w_coin_add);
      r_event_pending <= |w_pending_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= DS_IDLE;
      r_cnt        <= '0;
      r_nickel_out <= 1'b0;
      r_dime_out   <= 1'b0;
      r_vend       <= 1'b0;
    end else begin
      case (r_state)
        DS_IDLE: begin
          if (w_dispense_go) begin
            r_state      <= DS_PULSE;
            r_cnt        <= '0;
            r_nickel_out <= memory_write_value[0];
            r_dime_out   <= memory_write_value[1];
            r_vend       <= memory_write_value[2];
          end
        end
        DS_PULSE: begin
          if (r_cnt == PULSE_LAST) begin
            r_state      <= DS_GAP;
            r_cnt        <= '0;
            r_nickel_out <= 1'b0;
            r_dime_out   <= 1'b0;
            r_vend       <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DS_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= DS_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state      <= DS_IDLE;
          r_cnt        <= '0;
          r_nickel_out <= 1'b0;
          r_dime_out   <= 1'b0;
          r_vend       <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    memory_read_value = 32'd0;
    if (w_mapped) begin
      case (w_sel)
        REG_STATUS:   memory_read_value = {28'd0, w_busy, r_pending};
        REG_DISPENSE: memory_read_value = {29'd0, r_vend, r_dime_out, r_nickel_out};
        REG_CREDIT:   memory_read_value = {24'd0, r_credit};
        default:      memory_read_value = 32'd0;
      endcase
    end
  end

  // Byte-lane address bits and upper store-data bits have no destination.
  assign w_unused_bits = ^{memory_address[1:0], memory_write_value[31:8]};

  assign nickel_out    = r_nickel_out;
  assign dime_out      = r_dime_out;
  assign vend          = r_vend;
  assign event_pending = r_event_pending;

endmodule

// File: tb/tb_vending_io_responder.sv
// Scoreboard bench for vending_io_responder: stimulus pushes expected values,
// a negedge monitor pops and compares against the live DUT outputs.
module tb_vending_io_responder;

  localparam logic [31:0] A_STATUS = 32'h0;
  localparam logic [31:0] A_ACK    = 32'h4;
  localparam logic [31:0] A_DISP   = 32'h8;
  localparam logic [31:0] A_CREDIT = 32'hC;

  localparam int SEL_RD   = 0;
  localparam int SEL_EVP  = 1;
  localparam int SEL_OUTS = 2;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        memory_write_en = 1'b0;
  logic [31:0] memory_address = 32'd0;
  logic [31:0] memory_write_value = 32'd0;
  logic [31:0] memory_read_value;
  logic        nickel = 1'b0;
  logic        dime = 1'b0;
  logic        refund = 1'b0;
  logic        nickel_out;
  logic        dime_out;
  logic        vend;
  logic        event_pending;

  item_t       sb_q[$];
  item_t       mon_it;
  logic [31:0] mon_act;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clock = ~clock;

  vending_io_responder #(.PULSE_CYCLES(16), .GAP_CYCLES(16)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .memory_write_en(memory_write_en),
    .memory_address(memory_address),
    .memory_write_value(memory_write_value),
    .memory_read_value(memory_read_value),
    .nickel(nickel),
    .dime(dime),
    .refund(refund),
    .nickel_out(nickel_out),
    .dime_out(dime_out),
    .vend(vend),
    .event_pending(event_pending)
  );

  always @(negedge clock) begin
    while (sb_q.size() > 0) begin
      mon_it = sb_q.pop_front();
      case (mon_it.sel)
        SEL_RD:   mon_act = memory_read_value;
        SEL_EVP:  mon_act = {31'd0, event_pending};
        default:  mon_act = {29'd0, nickel_out, dime_out, vend};
      endcase
      tests_run++;
      if (mon_act !== mon_it.exp) begin
        tests_failed++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", mon_it.name, mon_act, mon_it.exp, $time);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input int sel, input logic [31:0] e, input string nm);
    item_t t;
    t.sel = sel;
    t.exp = e;
    t.name = nm;
    sb_q.push_back(t);
  endtask

  task automatic exp_rd(input logic [31:0] addr, input logic [31:0] e, input string nm);
    memory_address = addr;
    push(SEL_RD, e, nm);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    memory_write_en    = 1'b1;
    memory_address     = addr;
    memory_write_value = data;
    cyc(1);
    memory_write_en    = 1'b0;
    memory_write_value = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    reset_n = 1'b1;
    cyc(2);

    exp_rd(A_STATUS, 32'h0, "reset_status");
    push(SEL_OUTS, 32'h0, "reset_outs");
    push(SEL_EVP, 32'h0, "reset_evp");
    #1;
    tests_run++;
    if (memory_read_value !== 32'h0) begin
      tests_failed++;
      $display("FAIL direct_reset_status: got 0x%0h at %0t", memory_read_value, $time);
    end
    cyc();
    exp_rd(A_CREDIT, 32'h0, "reset_credit");
    cyc();

    // Nickel held 3 cycles, checked four cycles after it rose
    nickel = 1'b1; cyc(3); nickel = 1'b0; cyc();
    exp_rd(A_STATUS, 32'h1, "nickel_status");
    push(SEL_EVP, 32'h1, "nickel_evp");
    #1;
    tests_run++;
    if (memory_read_value !== 32'h1) begin
      tests_failed++;
      $display("FAIL direct_nickel_status: got 0x%0h at %0t", memory_read_value, $time);
    end
    tests_run++;
    if (event_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL direct_nickel_evp: got %0b at %0t", event_pending, $time);
    end
    cyc();
    exp_rd(A_CREDIT, 32'd5, "nickel_credit");
    cyc();

    wr(A_ACK, 32'h1);
    exp_rd(A_STATUS, 32'h0, "ack_clear");
    push(SEL_EVP, 32'h0, "ack_evp");
    cyc();

    dime = 1'b1; cyc(3); dime = 1'b0; cyc();
    exp_rd(A_CREDIT, 32'd15, "dime_credit"); cyc();
    exp_rd(A_STATUS, 32'h2, "dime_status"); cyc();
    wr(A_ACK, 32'h7);

    wr(A_CREDIT, 32'd100);
    exp_rd(A_CREDIT, 32'd100, "credit_store"); cyc();
    nickel = 1'b1; dime = 1'b1; cyc(3); nickel = 1'b0; dime = 1'b0; cyc();
    exp_rd(A_CREDIT, 32'd115, "both_credit"); cyc();
    wr(A_ACK, 32'h3);

    wr(A_CREDIT, 32'd250);
    nickel = 1'b1; dime = 1'b1; cyc(3); nickel = 1'b0; dime = 1'b0; cyc();
    exp_rd(A_CREDIT, 32'd255, "sat_credit"); cyc();
    exp_rd(A_STATUS, 32'h3, "sat_status"); cyc();
    wr(A_ACK, 32'h3);

    // CREDIT store lands in the same cycle as the nickel event
    nickel = 1'b1; cyc(2);
    wr(A_CREDIT, 32'd40);
    nickel = 1'b0;
    exp_rd(A_CREDIT, 32'd45, "store_plus_coin"); cyc();
    wr(A_ACK, 32'h1);
    exp_rd(A_STATUS, 32'h0, "ack_before_race"); cyc();

    // ACK lands in the same cycle as a new nickel event
    nickel = 1'b1; cyc(2);
    wr(A_ACK, 32'h1);
    nickel = 1'b0;
    exp_rd(A_STATUS, 32'h1, "ack_vs_event"); cyc();
    wr(A_ACK, 32'h7);

    wr(32'h10, 32'hFF);
    wr(32'h1C, 32'h77);
    exp_rd(32'h10, 32'h0, "unmapped_read"); cyc();
    exp_rd(32'h1C, 32'h0, "alias_read"); cyc();
    exp_rd(A_CREDIT, 32'd50, "unmapped_store"); cyc();

    wr(A_DISP, 32'h8);
    exp_rd(A_STATUS, 32'h0, "disp_zero_busy");
    push(SEL_OUTS, 32'h0, "disp_zero_outs");
    cyc();

    // Dime+vend pulse; a nickel store in mid-pulse must be ignored
    wr(A_DISP, 32'h6);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        memory_write_en    = 1'b1;
        memory_address     = A_DISP;
        memory_write_value = 32'h1;
        push(SEL_OUTS, 32'h3, "pulse_outs_busy_store");
      end else begin
        memory_write_en    = 1'b0;
        memory_write_value = 32'h0;
        exp_rd(A_STATUS, 32'h8, "pulse_busy");
        push(SEL_OUTS, 32'h3, "pulse_outs");
      end
      cyc();
    end
    memory_write_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_rd(A_STATUS, 32'h8, "gap_busy");
      push(SEL_OUTS, 32'h0, "gap_outs");
      cyc();
    end
    exp_rd(A_STATUS, 32'h0, "idle_after_gap");
    cyc();

    // Reset in mid vend pulse with refund held across release
    wr(A_DISP, 32'h4);
    cyc(4);
    refund = 1'b1;
    push(SEL_OUTS, 32'h1, "vend_before_rst");
    cyc();
    reset_n = 1'b0;
    #1;
    exp_rd(A_STATUS, 32'h0, "rst_mid_status");
    push(SEL_OUTS, 32'h0, "rst_mid_outs");
    push(SEL_EVP, 32'h0, "rst_mid_evp");
    cyc(3);
    exp_rd(A_CREDIT, 32'h0, "rst_mid_credit");
    cyc();
    reset_n = 1'b1;
    cyc(6);
    exp_rd(A_STATUS, 32'h0, "no_refund_evt");
    push(SEL_EVP, 32'h0, "no_refund_evp");
    cyc();
    refund = 1'b0; cyc(3);
    refund = 1'b1; cyc(3); refund = 1'b0;
    exp_rd(A_STATUS, 32'h4, "refund_evt");
    push(SEL_EVP, 32'h1, "refund_evp");
    #1;
    tests_run++;
    if (memory_read_value !== 32'h4) begin
      tests_failed++;
      $display("FAIL direct_refund_status: got 0x%0h at %0t", memory_read_value, $time);
    end
    tests_run++;
    if (event_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL direct_refund_evp: got %0b at %0t", event_pending, $time);
    end
    cyc();

    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    if (tests_failed != 0)
      $display("[TB] FAILED");
    else
      $display("[TB] PASSED");
    $finish;
  end

endmodule
